conv_window_sched: RTL

- Autonomous sequencer for the 3x3 convolution datapath: PE bank, K-column image window register and circular weight register.
- Replaces host-driven per-pixel trigger writes. After one start pulse it walks every output position of an IMG_H x IMG_W image (valid convolution, stride 1).
- Fetches window columns from the image buffer, clears and fires the PEs for K weight columns, then hands each result to the pack/writeback stage with a valid/ready handshake.

---
 rtl/conv_window_sched.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/conv_window_sched.sv
// conv_window_sched: autonomous scheduler that walks every valid 3x3
// output position, fetching window columns, firing PEs and handing results off.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      run request (IDLE only) / synchronous return to IDLE
//   busy, done        running flag / one-cycle completion pulse
//   col_rd_en/x/y     image column read request (data returns next cycle)
//   win_load          window shift strobe (col_rd_en delayed one cycle)
//   pe_clear          PE accumulator clear
//   mac_en, w_shift   PE accumulate enable and weight rotate (identical)
//   res_valid/ready   result handshake with pack/writeback
//   res_addr          linear address oy*OUT_W+ox of the current result
module conv_window_sched #(
    parameter int IMG_H  = 16,
    parameter int IMG_W  = 15,
    parameter int K      = 3,
    parameter int ADDR_W = 8,
    parameter int XW     = $clog2(IMG_W),
    parameter int YW     = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              col_rd_en,
    output logic [XW-1:0]     col_rd_x,
    output logic [YW-1:0]     col_rd_y,
    output logic              win_load,
    output logic              pe_clear,
    output logic              mac_en,
    output logic              w_shift,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_addr
);

    localparam int OUT_H = IMG_H - K + 1;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int CW    = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FILL,
        S_DRAIN,
        S_MAC,
        S_CAPT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       ox_q, ox_d;
    logic [YW-1:0]       oy_q, oy_d;
    logic [CW-1:0]       fc_q, fc_d;
    logic [CW-1:0]       kc_q, kc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                win_load_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ox_q       <= '0;
            oy_q       <= '0;
            fc_q       <= '0;
            kc_q       <= '0;
            addr_q     <= '0;
            win_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            fc_q       <= fc_d;
            kc_q       <= kc_d;
            addr_q     <= addr_d;
            win_load_q <= col_rd_en && !abort;
        end
    end

    always_comb begin
        state_d   = state_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        fc_d      = fc_q;
        kc_d      = kc_q;
        addr_d    = addr_q;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        col_rd_en = 1'b0;
        col_rd_x  = '0;
        col_rd_y  = '0;
        pe_clear  = 1'b0;
        mac_en    = 1'b0;
        res_valid = 1'b0;
        res_addr  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    ox_d    = '0;
                    oy_d    = '0;
                    addr_d  = '0;
                end
            end
            S_CLR: begin
                pe_clear = 1'b1;
                state_d  = S_FILL;
                // Sliding right reuses K-1 columns; only a row start refills fully.
                fc_d     = (ox_q == '0) ? '0 : CW'(K - 1);
            end
            S_FILL: begin
                col_rd_en = 1'b1;
                col_rd_x  = ox_q + XW'(fc_q);
                col_rd_y  = oy_q;
                if (fc_q == CW'(K - 1)) begin
                    state_d = S_DRAIN;
                    fc_d    = '0;
                end else begin
                    fc_d = fc_q + CW'(1);
                end
            end
            S_DRAIN: begin
                // Last column read lands in the window this cycle via win_load.
                state_d = S_MAC;
                kc_d    = '0;
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (kc_q == CW'(K - 1)) begin
                    state_d = S_CAPT;
                    kc_d    = '0;
                end else begin
                    kc_d = kc_q + CW'(1);
                end
            end
            S_CAPT: begin
                res_valid = 1'b1;
                res_addr  = addr_q;
                if (res_ready) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (ox_q != XW'(OUT_W - 1)) begin
                        ox_d    = ox_q + XW'(1);
                        state_d = S_CLR;
                    end else if (oy_q != YW'(OUT_H - 1)) begin
                        ox_d    = '0;
                        oy_d    = oy_q + YW'(1);
                        state_d = S_CLR;
                    end else begin
                        ox_d    = '0;
                        oy_d    = '0;
                        addr_d  = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            ox_d    = '0;
            oy_d    = '0;
            fc_d    = '0;
            kc_d    = '0;
            addr_d  = '0;
        end
    end

    assign win_load = win_load_q;
    assign w_shift  = mac_en;

endmodule
